// File: rtl/riscv_run_controller_pkg.sv
// riscv_run_pkg: shared constants for the RISC-V run/test controller.
//   - FSM state encoding (IDLE=0, RESET=1, RUN=2, DONE=3)
//   - result codes reported on the controller's result port
package riscv_run_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESET = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] RES_NONE    = 3'd0;
    localparam logic [2:0] RES_PASS    = 3'd1;
    localparam logic [2:0] RES_FAIL    = 3'd2;
    localparam logic [2:0] RES_TIMEOUT = 3'd3;
    localparam logic [2:0] RES_LOOP    = 3'd4;

endpackage

// File: rtl/riscv_run_controller_if.sv
// riscv_run_controller_if: core-side observation bus of the run controller.
//   pc        core program counter
//   mem_we    core data-memory write enable
//   mem_addr  core data-memory address
//   mem_wdata core data-memory write data
// master: the core (or a bench standing in for it) drives the bus.
// slave : the run controller samples it.
interface riscv_run_controller_if #(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0] pc;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;

    modport master (
        output pc,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        input pc,
        input mem_we,
        input mem_addr,
        input mem_wdata
    );

endinterface

// File: rtl/riscv_run_controller_pc_loop_detect.sv
// pc_loop_detect: flags a core stuck on one PC.
//   clk, rst  clock and synchronous active-high reset
//   clear     restart detection (new run accepted)
//   en        sample pc this cycle (controller in RUN)
//   pc        core program counter
//   loop_hit  this cycle's pc completes LOOP_THRESH consecutive identical samples
module pc_loop_detect #(
    parameter int XLEN        = 32,
    parameter int LOOP_THRESH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            en,
    input  logic [XLEN-1:0] pc,
    output logic            loop_hit
);

    localparam int LW = $clog2(LOOP_THRESH);
    // The counter holds (matches so far); the current matching sample would
    // bring it to LOOP_THRESH-1, so fire while it still reads LOOP_THRESH-2.
    localparam logic [LW-1:0] HIT_AT = LW'(LOOP_THRESH - 2);

    logic [XLEN-1:0] pc_prev;
    logic            prev_vld;
    logic [LW-1:0]   cnt;
    logic            same;

    assign same     = prev_vld && (pc == pc_prev);
    assign loop_hit = en && same && (cnt == HIT_AT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pc_prev  <= '0;
            prev_vld <= 1'b0;
            cnt      <= '0;
        end else if (en) begin
            pc_prev  <= pc;
            prev_vld <= 1'b1;
            cnt      <= same ? cnt + LW'(1) : '0;
        end
    end

endmodule

// File: rtl/riscv_run_controller.sv
// riscv_run_controller: run/test sequencer around a RISC-V core.
// Holds the core in reset, releases it, counts run cycles and ends the run on
// a tohost store (PASS/FAIL), a PC self-loop (LOOP) or a timeout (TIMEOUT).
//   clk, rst     clock and synchronous active-high reset
//   start        begin a run (accepted in IDLE or DONE)
//   core         observed core bus (pc, mem_we, mem_addr, mem_wdata)
//   core_rst_n   registered active-low reset to the core
//   busy / done  high in RESET or RUN / high in DONE
//   result       latched result code (riscv_run_pkg RES_*)
//   exit_code    mem_wdata>>1 on a tohost FAIL, else 0
//   cycle_count  RUN cycles elapsed, saturating
module riscv_run_controller
    import riscv_run_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              RESET_CYCLES = 2,
    parameter int              MAX_CYCLES   = 1000,
    parameter int              CNT_W        = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(32'h0000_0100),
    parameter int              LOOP_THRESH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    riscv_run_controller_if.slave core,
    output logic                 core_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           result,
    output logic [XLEN-1:0]      exit_code,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int            RW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       state;
    logic [RW-1:0]    rst_cnt;
    logic             in_run;
    logic             start_ok;
    logic             tohost_hit;
    logic             timeout_hit;
    logic             loop_hit;
    logic [CNT_W-1:0] cnt_next;

    assign in_run      = (state == ST_RUN);
    assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign cnt_next    = sat_inc(cycle_count);
    assign tohost_hit  = in_run && core.mem_we && (core.mem_addr == TOHOST_ADDR);
    // Timeout compares the count this edge will register, so the run ends
    // with cycle_count == MAX_CYCLES.
    assign timeout_hit = in_run && (cnt_next == MAX_CNT);

    assign busy = (state == ST_RESET) || (state == ST_RUN);
    assign done = (state == ST_DONE);

    pc_loop_detect #(
        .XLEN        (XLEN),
        .LOOP_THRESH (LOOP_THRESH)
    ) u_loop (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .en       (in_run),
        .pc       (core.pc),
        .loop_hit (loop_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            core_rst_n  <= 1'b0;
            result      <= RES_NONE;
            exit_code   <= '0;
            cycle_count <= '0;
            rst_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    core_rst_n <= 1'b0;
                    if (start) begin
                        state       <= ST_RESET;
                        cycle_count <= '0;
                        result      <= RES_NONE;
                        exit_code   <= '0;
                        rst_cnt     <= '0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= ST_RUN;
                        core_rst_n <= 1'b1;
                    end else begin
                        core_rst_n <= 1'b0;
                        rst_cnt    <= rst_cnt + RW'(1);
                    end
                end
                ST_RUN: begin
                    cycle_count <= cnt_next;
                    // Dropping core_rst_n on the event edge freezes the core.
                    if (tohost_hit) begin
                        state      <= ST_DONE;
                        core_rst_n <= 1'b0;
                        if (core.mem_wdata == XLEN'(1)) begin
                            result    <= RES_PASS;
                            exit_code <= '0;
                        end else begin
                            result    <= RES_FAIL;
                            exit_code <= core.mem_wdata >> 1;
                        end
                    end else if (loop_hit) begin
                        state      <= ST_DONE;
                        core_rst_n <= 1'b0;
                        result     <= RES_LOOP;
                    end else if (timeout_hit) begin
                        state      <= ST_DONE;
                        core_rst_n <= 1'b0;
                        result     <= RES_TIMEOUT;
                    end else begin
                        core_rst_n <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    core_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_run_controller.sv
// tb_riscv_run_controller: table-driven bench for riscv_run_controller.
// Each vector gives the inputs held across one rising edge and the outputs
// expected just after that edge.
module tb_riscv_run_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic [2:0]  result;
    logic [31:0] exit_code;
    logic [31:0] cycle_count;

    int n_cmp;
    int n_fail;

    riscv_run_controller_if #(.XLEN(32)) bus ();

    riscv_run_controller #(
        .XLEN         (32),
        .RESET_CYCLES (2),
        .MAX_CYCLES   (20),
        .CNT_W        (32),
        .TOHOST_ADDR  (32'h0000_0100),
        .LOOP_THRESH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .core        (bus),
        .core_rst_n  (core_rst_n),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .exit_code   (exit_code),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        we;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_crn;
        logic        e_busy;
        logic        e_done;
        logic [2:0]  e_res;
        logic [31:0] e_exit;
        logic [31:0] e_cc;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic s, input logic we,
                     input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wd,
                     input logic crn, input logic b, input logic d,
                     input logic [2:0] res, input logic [31:0] ex, input logic [31:0] cc);
        vec_t t;
        t.rst = r; t.start = s; t.we = we; t.pc = pc; t.addr = addr; t.wdata = wd;
        t.e_crn = crn; t.e_busy = b; t.e_done = d; t.e_res = res; t.e_exit = ex; t.e_cc = cc;
        vecs.push_back(t);
    endtask

    // start edge plus the two RESET edges; the last one enters RUN
    task automatic start_seq();
        v(0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t4_pc [10];
    logic        seen;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        bus.pc = '0;
        bus.mem_we = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;

        t4_pc = '{32'h40, 32'h40, 32'h44, 32'h40, 32'h40,
                  32'h48, 32'h40, 32'h40, 32'h40, 32'h40};

        // reset for two edges
        v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        // run 1: start ignored in RESET and RUN, tohost store in RESET ignored,
        // PASS store at RUN cycle 10, DONE holds against another store
        v(0, 1, 0, 0, 0, 0,          0, 1, 0, 0, 0, 0);
        v(0, 1, 1, 0, 32'h100, 1,    0, 1, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0,          1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++)
            v(0, (k == 5), 0, 32'h1000 + 32'(4 * k), 0, 0,   1, 1, 0, 0, 0, 32'(k));
        v(0, 0, 1, 32'h1028, 32'h100, 1,   0, 0, 1, 1, 0, 10);
        v(0, 0, 1, 32'h1028, 32'h100, 7,   0, 0, 1, 1, 0, 10);

        // run 2 from DONE: FAIL store with data 7
        start_seq();
        for (int k = 1; k <= 3; k++)
            v(0, 0, 0, 32'h2000 + 32'(4 * k), 0, 0,   1, 1, 0, 0, 0, 32'(k));
        v(0, 0, 1, 32'h2010, 32'h100, 7,   0, 0, 1, 2, 3, 4);

        // run 3: broken repeat does not fire, four identical PCs do;
        // a store to a neighbouring address is not tohost
        start_seq();
        for (int k = 1; k <= 9; k++)
            v(0, 0, (k == 2), t4_pc[k-1], 32'h104, 1,   1, 1, 0, 0, 0, 32'(k));
        v(0, 0, 0, t4_pc[9], 0, 0,   0, 0, 1, 4, 0, 10);

        // run 4: tohost PASS coinciding with timeout
        start_seq();
        for (int k = 1; k <= 19; k++)
            v(0, 0, 0, 32'h3000 + 32'(4 * k), 0, 0,   1, 1, 0, 0, 0, 32'(k));
        v(0, 0, 1, 32'h3050, 32'h100, 1,   0, 0, 1, 1, 0, 20);

        // run 5: rst at RUN cycle 5, stays IDLE, then restarts cleanly
        start_seq();
        for (int k = 1; k <= 4; k++)
            v(0, 0, 0, 32'h5000 + 32'(4 * k), 0, 0,   1, 1, 0, 0, 0, 32'(k));
        v(1, 0, 0, 32'h5014, 0, 0,   0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0);
        start_seq();
        v(0, 0, 0, 32'h6004, 0, 0,   1, 1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            rst           = vecs[i].rst;
            start         = vecs[i].start;
            bus.pc        = vecs[i].pc;
            bus.mem_we    = vecs[i].we;
            bus.mem_addr  = vecs[i].addr;
            bus.mem_wdata = vecs[i].wdata;
            tick();
            chk($sformatf("v%0d.core_rst_n", i), 32'(core_rst_n), 32'(vecs[i].e_crn));
            chk($sformatf("v%0d.busy", i),       32'(busy),       32'(vecs[i].e_busy));
            chk($sformatf("v%0d.done", i),       32'(done),       32'(vecs[i].e_done));
            chk($sformatf("v%0d.result", i),     32'(result),     32'(vecs[i].e_res));
            chk($sformatf("v%0d.exit_code", i),  exit_code,       vecs[i].e_exit);
            chk($sformatf("v%0d.cycle_count", i), cycle_count,    vecs[i].e_cc);
        end

        // timeout run with a bounded wait for done
        rst = 1'b1; start = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            bus.pc = 32'h4000 + 32'(4 * i);
            tick();
            if (done) seen = 1'b1;
        end
        chk("to.done_seen",   32'(seen),       32'd1);
        chk("to.result",      32'(result),     32'd3);
        chk("to.cycle_count", cycle_count,     32'd20);
        chk("to.exit_code",   exit_code,       32'd0);
        chk("to.core_rst_n",  32'(core_rst_n), 32'd0);

        // rst while in DONE clears the latched result
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rd.done",        32'(done),   32'd0);
        chk("rd.result",      32'(result), 32'd0);
        chk("rd.cycle_count", cycle_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
